// File: rtl/ahb_bus_pkg.sv
// rtl/ahb_bus_pkg.sv - shared bus state and response encodings for the AHB-lite interconnect
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

package ahb_bus_pkg;
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        RESP,
        ERR1,
        ERR2
    } bus_state_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
endpackage

// File: rtl/ahb_rr_arbiter.sv
// rtl/ahb_rr_arbiter.sv - round-robin requester pick starting after the last winner
module ahb_rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);
    logic [IW-1:0] ptr;

    always_comb begin
        logic found;
        int   cand;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(ptr) + i) % N;
            if (!found && req[cand]) begin
                found           = 1'b1;
                grant[cand]     = 1'b1;
                grant_idx       = IW'(cand);
            end
        end
    end

    // Pointer starts at the last master so master 0 wins the first contest.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= IW'(N - 1);
        end else if (advance && |req) begin
            ptr <= grant_idx;
        end
    end
endmodule

// File: rtl/ahb_lite_bus.sv
// rtl/ahb_lite_bus.sv - shared AHB-lite bus: rr arbitration, address decode, default slave, timeout
module ahb_lite_bus
    import ahb_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 2,
    parameter int ADDR_W      = `AHB_ADDR_WIDTH,
    parameter int DATA_W      = `AHB_DATA_WIDTH,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {32'hF000_0000, 32'hF000_0000},
    parameter int TIMEOUT     = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_MASTERS*ADDR_W-1:0] haddr,
    input  logic [NUM_MASTERS-1:0]        haddr_ctrl,
    input  logic [NUM_MASTERS-1:0]        hwrite,
    input  logic [NUM_MASTERS*DATA_W-1:0] hwdata,
    input  logic [NUM_MASTERS-1:0]        hbusreq,
    input  logic [NUM_SLAVES-1:0]         hready,
    input  logic [NUM_SLAVES-1:0]         hresp,
    input  logic [NUM_SLAVES*DATA_W-1:0]  hrdata,
    output logic [NUM_MASTERS-1:0]        hgrant,
    output logic [DATA_W-1:0]             hdata_s2m,
    output logic [NUM_MASTERS-1:0]        hresp_s2m,
    output logic [NUM_MASTERS-1:0]        hready_s2m,
    output logic [ADDR_W-1:0]             haddr_m2s,
    output logic [DATA_W-1:0]             hwdata_m2s,
    output logic                          hwrite_m2s,
    output logic [NUM_SLAVES-1:0]         hsel
);
    localparam int MW    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [NUM_MASTERS-1:0] M_ONE = NUM_MASTERS'(1);
    localparam logic [NUM_SLAVES-1:0]  S_ONE = NUM_SLAVES'(1);

    bus_state_t        state;
    logic [MW-1:0]     g;
    logic [SW-1:0]     s;
    logic [CNT_W-1:0]  cnt;

    logic [NUM_MASTERS-1:0] arb_grant;
    logic [MW-1:0]          arb_idx;
    logic [ADDR_W-1:0]      sel_addr;
    logic [NUM_SLAVES-1:0]  hit;
    logic                   dec_hit;
    logic [SW-1:0]          dec_idx;
    logic                   timed_out;

    ahb_rr_arbiter #(.N(NUM_MASTERS)) u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .req       (hbusreq),
        .advance   (state == IDLE),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign sel_addr = haddr[int'(g)*ADDR_W +: ADDR_W];

    // Map entries are listed io-first, so entry s sits at the MSB end of SLV_BASE/SLV_MASK.
    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_dec
        localparam int OFF = (NUM_SLAVES - 1 - i) * ADDR_W;
        assign hit[i] = (sel_addr & SLV_MASK[OFF +: ADDR_W]) == SLV_BASE[OFF +: ADDR_W];
    end

    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                dec_hit = 1'b1;
                dec_idx = SW'(i);
            end
        end
    end

    assign timed_out  = (TIMEOUT != 0) && ((int'(cnt) + 1) == TIMEOUT);
    assign hwdata_m2s = (state == DATA && hwrite_m2s) ? hwdata[int'(g)*DATA_W +: DATA_W] : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            g          <= '0;
            s          <= '0;
            cnt        <= '0;
            hgrant     <= '0;
            hdata_s2m  <= '0;
            hresp_s2m  <= '0;
            hready_s2m <= '0;
            haddr_m2s  <= '0;
            hwrite_m2s <= 1'b0;
            hsel       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    hresp_s2m  <= '0;
                    hready_s2m <= '0;
                    if (|hbusreq) begin
                        hgrant <= arb_grant;
                        g      <= arb_idx;
                        state  <= ADDR;
                    end
                end
                ADDR: begin
                    if (haddr_ctrl[g]) begin
                        haddr_m2s  <= sel_addr;
                        hwrite_m2s <= hwrite[g];
                        cnt        <= '0;
                        if (dec_hit) begin
                            hsel  <= S_ONE << dec_idx;
                            s     <= dec_idx;
                            state <= DATA;
                        end else begin
                            hresp_s2m <= M_ONE << g;
                            hdata_s2m <= '0;
                            state     <= ERR1;
                        end
                    end else if (!hbusreq[g]) begin
                        hgrant <= '0;
                        state  <= IDLE;
                    end
                end
                DATA: begin
                    if (hready[s]) begin
                        if (!hwrite_m2s) begin
                            hdata_s2m <= hrdata[int'(s)*DATA_W +: DATA_W];
                        end
                        hresp_s2m  <= (hresp[s] == HRESP_ERROR) ? (M_ONE << g) : '0;
                        hready_s2m <= M_ONE << g;
                        hsel       <= '0;
                        hgrant     <= '0;
                        state      <= RESP;
                    end else if (timed_out) begin
                        hsel      <= '0;
                        hresp_s2m <= M_ONE << g;
                        hdata_s2m <= '0;
                        state     <= ERR1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    hresp_s2m  <= '0;
                    hready_s2m <= '0;
                    state      <= IDLE;
                end
                ERR1: begin
                    hready_s2m <= M_ONE << g;
                    state      <= ERR2;
                end
                ERR2: begin
                    hresp_s2m  <= '0;
                    hready_s2m <= '0;
                    hgrant     <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_lite_bus.sv
// tb/tb_ahb_lite_bus.sv - self-checking bench for ahb_lite_bus
module tb_ahb_lite_bus;
    localparam int NM = 2;
    localparam int NS = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rstn;
    logic [NM*AW-1:0] haddr;
    logic [NM-1:0]    haddr_ctrl;
    logic [NM-1:0]    hwrite;
    logic [NM*DW-1:0] hwdata;
    logic [NM-1:0]    hbusreq;
    logic [NS-1:0]    hready;
    logic [NS-1:0]    hresp;
    logic [NS*DW-1:0] hrdata;
    logic [NM-1:0]    hgrant;
    logic [DW-1:0]    hdata_s2m;
    logic [NM-1:0]    hresp_s2m;
    logic [NM-1:0]    hready_s2m;
    logic [AW-1:0]    haddr_m2s;
    logic [DW-1:0]    hwdata_m2s;
    logic             hwrite_m2s;
    logic [NS-1:0]    hsel;

    int errors = 0;
    int checks = 0;
    int ptr;
    logic [DW-1:0] last_data;

    typedef struct {
        logic [NM-1:0] req;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        int            waits;
        logic          sresp;
        logic [DW-1:0] rd;
        int            e_m;
        logic [NS-1:0] e_hsel;
        logic          e_err;
        int            e_lat;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t tbl[8];

    ahb_lite_bus #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rstn(rstn), .haddr(haddr), .haddr_ctrl(haddr_ctrl), .hwrite(hwrite),
        .hwdata(hwdata), .hbusreq(hbusreq), .hready(hready), .hresp(hresp), .hrdata(hrdata),
        .hgrant(hgrant), .hdata_s2m(hdata_s2m), .hresp_s2m(hresp_s2m), .hready_s2m(hready_s2m),
        .haddr_m2s(haddr_m2s), .hwdata_m2s(hwdata_m2s), .hwrite_m2s(hwrite_m2s), .hsel(hsel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        checks++;
        if ($countones(hgrant) > 1 || $countones(hsel) > 1) begin
            errors++;
            $display("FAIL onehot: hgrant=%b hsel=%b expected at most one bit each", hgrant, hsel);
        end
    endtask

    function automatic int rr_pick(input logic [NM-1:0] req, input int p);
        for (int k = 1; k <= NM; k++) begin
            if (req[(p + k) % NM]) return (p + k) % NM;
        end
        return -1;
    endfunction

    function automatic int slave_of(input logic [AW-1:0] a);
        if (a[31:28] == 4'h1) return 0;
        if (a[31:28] == 4'h0) return 1;
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " hgrant"}, hgrant, 0);
        check({tag, " hsel"}, hsel, 0);
        check({tag, " hready_s2m"}, hready_s2m, 0);
        check({tag, " hresp_s2m"}, hresp_s2m, 0);
        check({tag, " hdata_s2m"}, hdata_s2m, 0);
        check({tag, " haddr_m2s"}, haddr_m2s, 0);
        check({tag, " hwdata_m2s"}, hwdata_m2s, 0);
        check({tag, " hwrite_m2s"}, hwrite_m2s, 0);
    endtask

    task automatic run_txn(input vec_t v);
        int   s;
        int   lat;
        logic errpath;
        s       = v.e_hsel[1] ? 1 : 0;
        errpath = v.e_err && (v.e_hsel == 0 || v.waits >= TO);
        hbusreq = v.req;
        step();
        check("grant", hgrant, 64'(1) << v.e_m);
        ptr = v.e_m;
        hwdata = {$urandom, $urandom};
        hwrite = NM'($urandom);
        haddr[v.e_m*AW +: AW]  = v.addr;
        hwdata[v.e_m*DW +: DW] = v.wd;
        hwrite[v.e_m]          = v.wr;
        haddr_ctrl[v.e_m]      = 1'b1;
        hready = '0;
        hresp  = '1;
        hrdata = {$urandom, $urandom};
        step();
        lat = 1;
        haddr_ctrl = '0;
        hbusreq    = '0;
        check("hsel", hsel, v.e_hsel);
        if (v.e_hsel != 0) check("haddr_m2s", haddr_m2s, v.addr);
        if (v.e_hsel != 0 && v.wr) check("hwdata_m2s", hwdata_m2s, v.wd);
        while (hready_s2m == 0 && lat < 40) begin
            if (lat == v.e_lat - 1) check("pre-ready hresp_s2m", hresp_s2m, errpath ? (64'(1) << v.e_m) : 0);
            hready = '1;
            hresp  = '1;
            if (v.e_hsel != 0) begin
                hready[s] = (lat > v.waits);
                hresp[s]  = v.sresp;
                hrdata[s*DW +: DW] = v.rd;
            end
            step();
            lat++;
        end
        check("latency", lat, v.e_lat);
        check("hready_s2m", hready_s2m, 64'(1) << v.e_m);
        check("hresp_s2m", hresp_s2m, 64'(v.e_err) << v.e_m);
        check("hdata_s2m", hdata_s2m, v.e_data);
        check("hsel at response", hsel, 0);
        last_data = v.e_data;
        hready = '0;
        hresp  = '0;
        step();
        check("idle hready_s2m", hready_s2m, 0);
        check("idle hresp_s2m", hresp_s2m, 0);
        check("idle hgrant", hgrant, 0);
    endtask

    function automatic vec_t model(input logic [NM-1:0] req, input logic wr, input logic [AW-1:0] addr,
                                   input logic [DW-1:0] wd, input int waits, input logic sresp,
                                   input logic [DW-1:0] rd);
        vec_t v;
        int   sl;
        v.req = req; v.wr = wr; v.addr = addr; v.wd = wd; v.waits = waits; v.sresp = sresp; v.rd = rd;
        v.e_m = rr_pick(req, ptr);
        sl = slave_of(addr);
        if (sl < 0) begin
            v.e_hsel = '0; v.e_err = 1'b1; v.e_lat = 2; v.e_data = '0;
        end else if (waits >= TO) begin
            v.e_hsel = NS'(1) << sl; v.e_err = 1'b1; v.e_lat = TO + 2; v.e_data = '0;
        end else begin
            v.e_hsel = NS'(1) << sl; v.e_err = sresp; v.e_lat = waits + 2;
            v.e_data = wr ? last_data : rd;
        end
        return v;
    endfunction

    initial begin
        vec_t v;
        int   m;
        tbl[0] = '{2'b01, 1'b0, 32'h0000_0010, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 0, 2'b10, 1'b0, 2, 32'hDEAD_BEEF};
        tbl[1] = '{2'b11, 1'b1, 32'h1000_0004, 32'h55, 5, 1'b0, 32'h0, 1, 2'b01, 1'b0, 7, 32'hDEAD_BEEF};
        tbl[2] = '{2'b11, 1'b0, 32'h1000_0008, 32'h0, 0, 1'b0, 32'h1234, 0, 2'b01, 1'b0, 2, 32'h1234};
        tbl[3] = '{2'b11, 1'b0, 32'h0000_0100, 32'h0, 2, 1'b1, 32'hCAFE_F00D, 1, 2'b10, 1'b1, 4, 32'hCAFE_F00D};
        tbl[4] = '{2'b01, 1'b0, 32'h2000_0000, 32'h0, 0, 1'b0, 32'h0, 0, 2'b00, 1'b1, 2, 32'h0};
        tbl[5] = '{2'b10, 1'b0, 32'h0000_0040, 32'h0, 16, 1'b0, 32'h0, 1, 2'b10, 1'b1, 18, 32'h0};
        tbl[6] = '{2'b01, 1'b0, 32'h0000_0000, 32'h0, 15, 1'b0, 32'hA5A5_A5A5, 0, 2'b10, 1'b0, 17, 32'hA5A5_A5A5};
        tbl[7] = '{2'b11, 1'b1, 32'h1FFF_FFFC, 32'h77, 1, 1'b0, 32'h0, 1, 2'b01, 1'b0, 3, 32'hA5A5_A5A5};

        rstn = 1'b0;
        haddr = '0; haddr_ctrl = '0; hwrite = '0; hwdata = '0; hbusreq = '0;
        hready = '0; hresp = '0; hrdata = '0;
        ptr = NM - 1;
        last_data = '0;
        step();
        step();
        check_all_zero("reset");
        rstn = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_txn(tbl[i]);

        // Requester gives up before presenting an address.
        m = rr_pick(2'b01, ptr);
        hbusreq = 2'b01;
        step();
        check("abandon grant", hgrant, 64'(1) << m);
        ptr = m;
        hbusreq = '0;
        step();
        check("abandon hgrant cleared", hgrant, 0);
        step();
        check("abandon stays idle", hgrant, 0);

        for (int i = 0; i < 24; i++) begin
            logic [AW-1:0] a;
            int            region;
            int            w;
            region = $urandom_range(0, 4);
            a = $urandom;
            a[31:28] = (region == 0) ? 4'h0 : (region == 1) ? 4'h1 : (region == 2) ? 4'h0 :
                       (region == 3) ? 4'h1 : 4'($urandom_range(2, 15));
            w = ($urandom_range(0, 7) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, 4);
            v = model(NM'($urandom_range(1, 3)), 1'($urandom), a, $urandom, w,
                      ($urandom_range(0, 3) == 0), $urandom);
            run_txn(v);
        end

        // Reset in the middle of a write data phase.
        m = rr_pick(2'b10, ptr);
        hbusreq = 2'b10;
        step();
        haddr[m*AW +: AW] = 32'h1000_0020;
        hwdata[m*DW +: DW] = 32'h0BAD_F00D;
        hwrite[m] = 1'b1;
        haddr_ctrl[m] = 1'b1;
        hready = '0;
        step();
        haddr_ctrl = '0;
        hbusreq = '0;
        step();
        check("pre-reset hwdata_m2s", hwdata_m2s, 32'h0BAD_F00D);
        check("pre-reset hsel", hsel, 2'b01);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("async reset");
        step();
        rstn = 1'b1;
        ptr = NM - 1;
        last_data = '0;
        step();

        for (int r = 0; r < 3; r++) begin
            v = model(2'b11, 1'b0, 32'h1000_0000 + 32'(r * 4), 32'h0, 0, 1'b0, 32'h100 + 32'(r));
            check("post-reset rr order", v.e_m, r % 2);
            run_txn(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
